// File: rtl/posl_parl_pkg.sv
// Shared types and sizing helpers for the posl_parl deserializer.
// POSL_PARL_PARITY_EN adds one trailing even-parity bit per frame.
package posl_parl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

`ifdef POSL_PARL_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  // FRAME_LEN for a given word width
  function automatic int frame_len(input int width);
    return width + PAR_BITS;
  endfunction

endpackage

// File: rtl/posl_parl_outreg.sv
// Valid/ready output holding register with overrun pulse.
// Ports: clk, reset, load, din -> dout, valid; ready in; overrun out.
module posl_parl_outreg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          valid,
  input  logic          ready,
  output logic          overrun
);

  logic take;
  logic drop;
  logic drain;

  // A load is accepted when the slot is free or is being
  // emptied on this same edge (back-to-back throughput).
  assign take  = load && (!valid || ready);
  assign drop  = load && valid && !ready;
  assign drain = !load && valid && ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      dout    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      unique case (1'b1)
        take: begin
          dout  <= din;
          valid <= 1'b1;
        end
        drop:    overrun <= 1'b1;
        drain:   valid   <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/posl_parl.sv
// Serial-to-parallel deserializer with valid/ready word output.
// Ports: clk, reset, ser_in, ser_valid, frame_start -> par_out,
// par_valid, par_ready(in), busy, overrun; par_err with
// POSL_PARL_PARITY_EN defined.
module posl_parl
  import posl_parl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             busy,
  output logic             overrun
`ifdef POSL_PARL_PARITY_EN
  ,
  output logic             par_err
`endif
);

  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam int CW        = cnt_w(WIDTH);
  localparam int OW        = WIDTH + PAR_BITS;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_n;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first;
  logic [WIDTH-1:0] word;
  logic             load;
  logic [OW-1:0]    din;
  logic [OW-1:0]    dout;

  logic do_start;
  logic do_last;
  logic do_shift;

`ifdef POSL_PARL_PARITY_EN
  logic acc;
  logic acc_n;
  logic err;
`endif

  assign do_start = ser_valid && frame_start;
  assign do_last  = ser_valid && !frame_start
                 && state == SHIFT && cnt == LAST;
  assign do_shift = ser_valid && !frame_start
                 && state == SHIFT && cnt != LAST;

  // A new frame shifts into a cleared register so stale
  // bits from an aborted frame never leak into the word.
  always_comb begin
    if (MSB_FIRST) begin
      shifted = {shreg[WIDTH-2:0], ser_in};
      first   = {{(WIDTH-1){1'b0}}, ser_in};
    end else begin
      shifted = {ser_in, shreg[WIDTH-1:1]};
      first   = {ser_in, {(WIDTH-1){1'b0}}};
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    load    = 1'b0;
    word    = shifted;
`ifdef POSL_PARL_PARITY_EN
    acc_n   = acc;
    err     = 1'b0;
`endif
    unique case (1'b1)
      do_start: begin
        state_n = SHIFT;
        cnt_n   = CW'(1);
        shreg_n = first;
`ifdef POSL_PARL_PARITY_EN
        acc_n   = ser_in;
`endif
      end
      do_last: begin
        state_n = IDLE;
        cnt_n   = '0;
        load    = 1'b1;
`ifdef POSL_PARL_PARITY_EN
        // final bit is parity, data already complete
        word    = shreg;
        err     = acc ^ ser_in;
`else
        shreg_n = shifted;
`endif
      end
      do_shift: begin
        cnt_n   = cnt + CW'(1);
        shreg_n = shifted;
`ifdef POSL_PARL_PARITY_EN
        acc_n   = acc ^ ser_in;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
`ifdef POSL_PARL_PARITY_EN
      acc   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      shreg <= shreg_n;
`ifdef POSL_PARL_PARITY_EN
      acc   <= acc_n;
`endif
    end
  end

  assign busy = (state == SHIFT);

`ifdef POSL_PARL_PARITY_EN
  assign din = {err, word};
  assign {par_err, par_out} = dout;
`else
  assign din     = word;
  assign par_out = dout;
`endif

  posl_parl_outreg #(
    .DW(OW)
  ) u_outreg (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .din    (din),
    .dout   (dout),
    .valid  (par_valid),
    .ready  (par_ready),
    .overrun(overrun)
  );

endmodule

// File: tb/tb_posl_parl.sv
// Scoreboard bench for posl_parl: MSB-first and LSB-first
// instances share one randomized serial stream.
module tb_posl_parl;

  localparam int W = 8;
`ifdef POSL_PARL_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clk = 1'b0;
  logic reset;
  logic ser_in;
  logic ser_valid;
  logic frame_start;
  logic par_ready;

  logic [W-1:0] out0;
  logic [W-1:0] out1;
  logic v0, v1, b0, b1, o0, o1;
`ifdef POSL_PARL_PARITY_EN
  logic e0, e1;
`endif

  always #5 clk = ~clk;

  posl_parl #(.WIDTH(W), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .reset(reset), .ser_in(ser_in),
    .ser_valid(ser_valid), .frame_start(frame_start),
    .par_out(out0), .par_valid(v0), .par_ready(par_ready),
    .busy(b0), .overrun(o0)
`ifdef POSL_PARL_PARITY_EN
    , .par_err(e0)
`endif
  );

  posl_parl #(.WIDTH(W), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .reset(reset), .ser_in(ser_in),
    .ser_valid(ser_valid), .frame_start(frame_start),
    .par_out(out1), .par_valid(v1), .par_ready(par_ready),
    .busy(b1), .overrun(o1)
`ifdef POSL_PARL_PARITY_EN
    , .par_err(e1)
`endif
  );

  typedef struct {
    logic [W-1:0] w;
    logic         e;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t x0, x1;

  int checks   = 0;
  int failures = 0;

  // reference model state: bits of the current frame,
  // whether a frame is open, whether the output slot is full
  bit   mq[$];
  bit   in_frame = 1'b0;
  bit   occ      = 1'b0;
  bit   rdy_v    = 1'b1;
  bit   mon_en   = 1'b0;
  logic e_busy   = 1'b0;
  logic e_ovr    = 1'b0;
  logic e_valid  = 1'b0;
  logic pv0      = 1'b0;
  logic pv1      = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic model();
    bit   done;
    bit   par;
    exp_t a, b;
    if (reset) begin
      mq.delete();
      q0.delete();
      q1.delete();
      in_frame = 1'b0;
      occ      = 1'b0;
      e_busy   = 1'b0;
      e_ovr    = 1'b0;
      e_valid  = 1'b0;
      return;
    end
    done = 1'b0;
    if (ser_valid) begin
      if (frame_start) begin
        mq.delete();
        mq.push_back(ser_in);
        in_frame = 1'b1;
      end else if (in_frame) begin
        mq.push_back(ser_in);
        if (mq.size() == FL) begin
          done     = 1'b1;
          in_frame = 1'b0;
        end
      end
    end
    e_ovr = 1'b0;
    if (done) begin
      a.w = '0;
      b.w = '0;
      par = 1'b0;
      for (int i = 0; i < W; i++) begin
        a.w[W-1-i] = mq[i];
        b.w[i]     = mq[i];
      end
      for (int i = 0; i < FL; i++) par ^= mq[i];
      a.e = par;
      b.e = par;
      if (!occ || par_ready) begin
        q0.push_back(a);
        q1.push_back(b);
        occ = 1'b1;
      end else begin
        e_ovr = 1'b1;
      end
    end else if (occ && par_ready) begin
      occ = 1'b0;
    end
    e_busy  = in_frame;
    e_valid = occ;
  endtask

  // monitor: compares status every cycle, pops a word
  // whenever a fresh word appears on the output
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy0", 32'(b0), 32'(e_busy));
      chk("busy1", 32'(b1), 32'(e_busy));
      chk("valid0", 32'(v0), 32'(e_valid));
      chk("valid1", 32'(v1), 32'(e_valid));
      chk("overrun0", 32'(o0), 32'(e_ovr));
      chk("overrun1", 32'(o1), 32'(e_ovr));
      if (v0 === 1'b1 && (!pv0 || par_ready)) begin
        if (q0.size() == 0) begin
          chk("word0_unexpected", 32'(out0), 32'hDEAD);
        end else begin
          x0 = q0.pop_front();
          chk("word0", 32'(out0), 32'(x0.w));
`ifdef POSL_PARL_PARITY_EN
          chk("err0", 32'(e0), 32'(x0.e));
`endif
        end
      end
      if (v1 === 1'b1 && (!pv1 || par_ready)) begin
        if (q1.size() == 0) begin
          chk("word1_unexpected", 32'(out1), 32'hDEAD);
        end else begin
          x1 = q1.pop_front();
          chk("word1", 32'(out1), 32'(x1.w));
`ifdef POSL_PARL_PARITY_EN
          chk("err1", 32'(e1), 32'(x1.e));
`endif
        end
      end
    end
    pv0 = v0;
    pv1 = v1;
  end

  task automatic step(input logic rs, input logic sv,
                      input logic fs, input logic b);
    @(negedge clk);
    #1;
    reset       = rs;
    ser_valid   = sv;
    frame_start = fs;
    ser_in      = b;
    par_ready   = rdy_v;
    model();
    if (rs) mon_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_out0", 32'(out0), 32'h0);
    chk("rst_out1", 32'(out1), 32'h0);
`ifdef POSL_PARL_PARITY_EN
    chk("rst_err0", 32'(e0), 32'h0);
`endif
  endtask

  // word bits go out from bit W-1 down to bit 0, then the
  // parity bit (flipped when pflip is set)
  task automatic send(input logic [W-1:0] w, input bit gap,
                      input int nb, input bit pflip);
    logic b;
    for (int i = 0; i < nb; i++) begin
      if (i < W) b = w[W-1-i];
      else       b = (^w) ^ pflip;
      if (gap && i > 0)
        step(1'b0, 1'b0, 1'b1, 1'($urandom % 2));
      step(1'b0, 1'b1, (i == 0), b);
    end
  endtask

  initial begin
    logic sv;
    logic fs;
    do_reset();
    rdy_v = 1'b1;
    send(8'hA5, 1'b0, FL, 1'b0);
    idle(2);
    send(8'h01, 1'b0, FL, 1'b0);
    idle(2);
    send(8'h3C, 1'b1, FL, 1'b0);
    idle(2);
    rdy_v = 1'b0;
    send(8'h11, 1'b0, FL, 1'b0);
    send(8'h22, 1'b0, FL, 1'b0);
    idle(2);
    rdy_v = 1'b1;
    idle(1);
    rdy_v = 1'b0;
    idle(2);
    rdy_v = 1'b1;
    send(8'hFF, 1'b0, 4, 1'b0);
    send(8'h0F, 1'b0, FL, 1'b0);
    idle(2);
    send(8'hC3, 1'b0, 5, 1'b0);
    do_reset();
    send(8'h5A, 1'b0, FL, 1'b0);
    idle(2);
`ifdef POSL_PARL_PARITY_EN
    send(8'h07, 1'b0, FL, 1'b0);
    idle(1);
    send(8'h07, 1'b0, FL, 1'b1);
    idle(2);
`endif
    // back-to-back frames under full throughput
    send(8'h96, 1'b0, FL, 1'b0);
    send(8'h69, 1'b0, FL, 1'b0);
    idle(2);
    for (int i = 0; i < 3000; i++) begin
      sv = 1'($urandom % 4 != 0);
      fs = sv && ($urandom % (in_frame ? 16 : 3) == 0);
      rdy_v = ($urandom % 3 != 0);
      step(1'($urandom % 700 == 0), sv, fs, 1'($urandom % 2));
    end
    rdy_v = 1'b1;
    idle(4);
    @(negedge clk);
    chk("q0_left", q0.size(), 0);
    chk("q1_left", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
